// File: rtl/add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_ctrl_pkg
// Brief    : Shared types and default sizing for the chunked add controller.
// Revision : 1.0 - initial release
// ============================================================================
package add_ctrl_pkg;

    localparam int c_default_n = 8;
    localparam int c_default_k = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : add_ctrl_pkg
`default_nettype wire

// File: rtl/chunked_add_ctrl_rca.sv
`default_nettype none
// ============================================================================
// Module   : rca
// Brief    : N-bit ripple-carry adder, the single arithmetic element shared by
//            every chunk of the controller.
// Revision : 1.0 - initial release
// ============================================================================
module rca #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[N];

endmodule : rca
`default_nettype wire

// File: rtl/chunked_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chunked_add_ctrl
// Brief    : Adds/subtracts W = N*K bit operands over K clocks through one
//            shared N-bit ripple-carry adder, LSB chunk first.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_add_ctrl
    import add_ctrl_pkg::*;
#(
    parameter  int N = c_default_n,
    parameter  int K = c_default_k,
    localparam int W = N * K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         overflow,
    output logic         busy
);

    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [N-1:0]     w_chunk_a;
    logic [N-1:0]     w_chunk_b;
    logic [N-1:0]     w_rca_sum;
    logic             w_rca_cout;
    logic             w_last;
    logic             w_accept;

    // Select the operand chunk addressed by the current index.
    always_comb begin
        w_chunk_a = '0;
        w_chunk_b = '0;
        for (int k = 0; k < K; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_chunk_a = r_a[k*N +: N];
                w_chunk_b = r_b[k*N +: N];
            end
        end
    end

    rca #(
        .N (N)
    ) u_rca (
        .a    (w_chunk_a),
        .b    (w_chunk_b),
        .cin  (r_carry),
        .sum  (w_rca_sum),
        .cout (w_rca_cout)
    );

    assign w_last   = (r_idx == IDX_W'(K - 1));
    assign w_accept = (r_state == IDLE) && in_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // Subtraction is folded into the capture: B is inverted once and the
    // initial carry supplies the +1, so the run phase is identical for both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == RUN) begin
            for (int k = 0; k < K; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    r_sum[k*N +: N] <= w_rca_sum;
                end
            end
            r_carry <= w_rca_cout;
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= w_rca_cout;
                r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_rca_sum[N-1] != r_a[W-1]);
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

endmodule : chunked_add_ctrl
`default_nettype wire

// File: tb/tb_chunked_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_add_ctrl
// Brief    : Self-checking bench for chunked_add_ctrl (N=8, K=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_add_ctrl;

    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    chunked_add_ctrl #(
        .N (N),
        .K (K)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    vec_t         tbl [8];
    exp_t         sb [$];
    int           n_tests;
    int           n_fail;
    int           n_hs;
    int           n_done;
    int           cyc;
    int           acc_h;
    int           last_h;
    bit           have_last;
    bit           spacing_on;
    bit           prev_ov;
    logic [W-1:0] exp_s;
    logic         exp_c;
    logic         exp_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Scoreboard push on input handshake, pop and compare on output handshake.
    task monitor();
        int h;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ov = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    e.s = exp_s; e.c = exp_c; e.o = exp_o;
                    sb.push_back(e);
                    h = cyc + 1;
                    if (spacing_on) begin
                        if (have_last) chk("hs_spacing", W'(h - last_h), W'(K + 2));
                        have_last = 1'b1;
                    end
                    last_h = h;
                    acc_h  = h;
                    n_hs++;
                end
                if (out_valid && !prev_ov) chk("latency", W'(cyc - acc_h), W'(K));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_empty", W'(1), W'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("sum", sum, e.s);
                        chk("cout", W'(cout), W'(e.c));
                        chk("overflow", W'(overflow), W'(e.o));
                    end
                    n_done++;
                end
                prev_ov = out_valid;
            end
        end
    endtask

    task wait_done(input int target);
        int t;
        t = 0;
        while (n_done < target && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (n_done < target) chk("result_timeout", W'(n_done), W'(target));
        @(posedge clk);
        #1;
    endtask

    task run_op(input vec_t v);
        int tgt;
        tgt      = n_done + 1;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        sub      = v.sub;
        exp_s    = v.es;
        exp_c    = v.ec;
        exp_o    = v.eo;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(tgt);
    endtask

    task chk_reset_vals(string tag);
        chk({tag, "_in_ready"},  W'(in_ready),  W'(1));
        chk({tag, "_out_valid"}, W'(out_valid), W'(0));
        chk({tag, "_busy"},      W'(busy),      W'(0));
        chk({tag, "_sum"},       sum,           W'(0));
        chk({tag, "_cout"},      W'(cout),      W'(0));
        chk({tag, "_overflow"},  W'(overflow),  W'(0));
    endtask

    initial begin
        logic [W:0]   t33;
        logic [W-1:0] beff;
        vec_t         v;
        int           tgt;
        int           t;

        n_tests = 0; n_fail = 0; n_hs = 0; n_done = 0;
        acc_h = 0; last_h = 0; have_last = 0; spacing_on = 0; prev_ov = 0;
        exp_s = '0; exp_c = 0; exp_o = 0;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[2] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[5] = '{32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
        tbl[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        fork
            monitor();
        join_none
        #3;
        chk_reset_vals("por");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_op(tbl[i]);

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        a = 32'h0000_0010; b = 32'h0000_0020; cin = 1'b0; sub = 1'b0;
        exp_s = 32'h0000_0030; exp_c = 1'b0; exp_o = 1'b0;
        tgt = n_done + 1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_reach_done", W'(out_valid), W'(1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            chk("bp_out_valid", W'(out_valid), W'(1));
            chk("bp_in_ready",  W'(in_ready),  W'(0));
            chk("bp_sum",       sum,           32'h0000_0030);
            chk("bp_cout",      W'(cout),      W'(0));
            chk("bp_overflow",  W'(overflow),  W'(0));
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", W'(out_valid), W'(0));
        chk("bp_release_in_ready",  W'(in_ready),  W'(1));
        chk("bp_popped", W'(n_done), W'(tgt));

        // Reset in the middle of RUN, after the third chunk edge is pending.
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; cin = 1'b0; sub = 1'b0;
        exp_s = '0; exp_c = 1'b0; exp_o = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_run");
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        v = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
        run_op(v);

        // Back-to-back random traffic against a reference model.
        spacing_on = 1'b1;
        have_last  = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a    = $urandom;
            b    = $urandom;
            cin  = 1'($urandom_range(0, 1));
            sub  = 1'($urandom_range(0, 1));
            beff = sub ? ~b : b;
            t33  = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
            exp_s = t33[W-1:0];
            exp_c = t33[W];
            exp_o = (a[W-1] == beff[W-1]) && (t33[W-1] != a[W-1]);
            tgt = n_hs + 1;
            t = 0;
            while (n_hs < tgt && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (n_hs < tgt) chk("hs_timeout", W'(n_hs), W'(tgt));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_done(n_done + sb.size());
        spacing_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_chunked_add_ctrl
`default_nettype wire
